nrzi_up: RTL and testbench
==========================

// Module: nrzi_up
// PURPOSE
//  Transmit-side NRZI encoder and EOP sequencer for the SIE upstream path.
//  Takes an already bit-stuffed serial stream, one bit per bit-time strobe,
//  and drives the bus as bus_t levels (USB_J / USB_K / USB_SE0), with an output enable.
//  Frames each packet: one J lead-in bit-time, the encoded bits, EOP_SE0_BITS of SE0,
//  EOP_J_BITS of J, then releases the bus. Sits between the bit stuffer and the bus driver.
// PARAMETERS
//  EOP_SE0_BITS  2  bit-times of SE0 in EOP (legal range 1..7)
//  EOP_J_BITS    1  bit-times of driven J after SE0, before oe drops (legal range 1..7)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  en         in   1      bit-time strobe; all state advances only when en=1
//  start      in   1      request to begin a packet (level; sampled in IDLE on en)
//  bit_in     in   1      stuffed data bit; 0 = transition, 1 = hold
//  bit_valid  in   1      bit_in valid for this bit-time
//  eop_req    in   1      end packet (sampled in ACTIVE on en)
//  bit_taken  out  1      1-clk pulse: bit_in consumed this cycle
//  tx_out     out  bus_t  encoded line level (registered)
//  tx_oe      out  1      drive enable (registered)
//  busy       out  1      state != IDLE
//  done       out  1      1-clk pulse when final EOP J bit-time ends
//  underrun   out  1      1-clk pulse: ACTIVE, en=1, bit_valid=0, eop_req=0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, tx_out=USB_J, tx_oe=0, level reg=J,
//   counters=0, all pulses 0. Reset mid-packet abandons the packet; no EOP is sent.
//  en=0: no state, level, counter or output change; pulse outputs are 0.
//  States:
//   IDLE : tx_oe=0, tx_out=J. On en & start -> ACTIVE; next clk tx_oe=1, tx_out=J
//          (lead-in bit-time); level reg=J. start is ignored outside IDLE.
//   ACTIVE: on en:
//     eop_req=1           -> EOP_SE0, cnt=1; tx_out=SE0 next clk; bit NOT taken
//                            (eop_req wins over a simultaneous bit_valid).
//     bit_valid=1         -> bit_taken pulses combinationally in this cycle;
//                            level'=bit_in ? level : ~level (J<->K); tx_out=level' next clk.
//     neither             -> hold level and tx_out; underrun pulses; stay ACTIVE.
//   EOP_SE0: tx_out=SE0. On en: if cnt==EOP_SE0_BITS -> EOP_J, cnt=1, tx_out=J;
//            else cnt++.
//   EOP_J : tx_out=J, tx_oe=1. On en: if cnt==EOP_J_BITS -> IDLE, tx_oe=0, done
//           pulses for the clk of that transition, level reg=J; else cnt++.
//  Latency: a bit taken on clock edge N appears on tx_out after edge N (1 clk,
//   registered). Each bus state persists exactly one bit-time between en strobes.
//  Level reg is only J or K; SE0 is never produced by toggling. tx_out never
//   shows SE0 outside EOP_SE0. tx_out=SE0 only while tx_oe=1.
//  cnt is 3 bits wide and saturation-free given the legal parameter range.
//  start held high through done re-arms: IDLE on the next en -> ACTIVE.
//   Minimum inter-packet gap: 1 bit-time of IDLE.
// TESTING
//  1. Reset, start=1 on en, then 8 bits 0000_0001 (SYNC) valid, then eop_req
//     -> tx_out per bit-time: J(lead),K,J,K,J,K,J,K,K,SE0,SE0,J; then tx_oe=0;
//     done pulse once; bit_taken x8.
//  2. ACTIVE with bits 1,1,1 from level K -> tx_out stays K for 3 bit-times;
//     bit_taken x3.
//  3. eop_req and bit_valid together in ACTIVE (bit_in=0) -> bit_taken=0; next tx_out=SE0.
//  4. ACTIVE, en=1, bit_valid=0, eop_req=0 -> underrun pulse; tx_out unchanged.
//     en=0 for 5 clks -> all outputs frozen.
//  5. Assert rst_n=0 asynchronously mid-EOP_SE0 -> immediately tx_oe=0, tx_out=J,
//     busy=0, no done pulse.
//  6. EOP_SE0_BITS=3, EOP_J_BITS=2 -> SE0,SE0,SE0,J,J, then tx_oe=0.
//     start held high -> new packet begins after 1 IDLE bit-time.

Source files
------------

// File: rtl/nrzi_up.sv
`default_nettype none
// ============================================================================
//  Module   : nrzi_up
//  Brief    : Upstream NRZI encoder and EOP sequencer. Frames each packet as
//             one J lead-in bit-time, NRZI-encoded stuffed bits, a run of
//             SE0 and a run of driven J, then releases the bus.
//             Bus level encoding on tx_out is {dp, dm}:
//               J = 2'b10, K = 2'b01, SE0 = 2'b00.
//  Revision : 1.0  initial release
// ============================================================================
module nrzi_up #(
  parameter int EOP_SE0_BITS = 2,  // bit-times of SE0 in EOP (1..7)
  parameter int EOP_J_BITS   = 1   // bit-times of driven J after SE0 (1..7)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       start,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       eop_req,
  output logic       bit_taken,
  output logic [1:0] tx_out,
  output logic       tx_oe,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam logic [1:0] USB_J   = 2'b10;
  localparam logic [1:0] USB_K   = 2'b01;
  localparam logic [1:0] USB_SE0 = 2'b00;

  // Last count value of each EOP phase; counters start at 1 on phase entry.
  localparam logic [2:0] C_SE0_LAST = 3'(EOP_SE0_BITS);
  localparam logic [2:0] C_J_LAST   = 3'(EOP_J_BITS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_EOP_SE0 = 2'd2,
    S_EOP_J   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       level_q, level_d;   // current NRZI level: 0 = J, 1 = K
  logic [1:0] tx_out_q, tx_out_d;
  logic       tx_oe_q, tx_oe_d;

  // State, level, counter and line registers; reset abandons any packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      level_q  <= 1'b0;
      tx_out_q <= USB_J;
      tx_oe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      tx_out_q <= tx_out_d;
      tx_oe_q  <= tx_oe_d;
    end
  end

  // Next-state and pulse logic; nothing moves unless the bit-time strobe is high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    tx_out_d  = tx_out_q;
    tx_oe_d   = tx_oe_q;
    bit_taken = 1'b0;
    underrun  = 1'b0;
    done      = 1'b0;

    if (en) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_ACTIVE;
            tx_oe_d  = 1'b1;
            tx_out_d = USB_J;      // lead-in bit-time
            level_d  = 1'b0;
          end
        end

        S_ACTIVE: begin
          if (eop_req) begin
            // End of packet takes priority; a pending bit is left unconsumed.
            state_d  = S_EOP_SE0;
            cnt_d    = 3'd1;
            tx_out_d = USB_SE0;
          end else if (bit_valid) begin
            bit_taken = 1'b1;
            // NRZI: a 0 toggles the line, a 1 holds it.
            level_d   = bit_in ? level_q : ~level_q;
            tx_out_d  = level_d ? USB_K : USB_J;
          end else begin
            underrun = 1'b1;
          end
        end

        S_EOP_SE0: begin
          if (cnt_q == C_SE0_LAST) begin
            state_d  = S_EOP_J;
            cnt_d    = 3'd1;
            tx_out_d = USB_J;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end

        S_EOP_J: begin
          if (cnt_q == C_J_LAST) begin
            state_d  = S_IDLE;
            cnt_d    = 3'd0;
            tx_oe_d  = 1'b0;
            tx_out_d = USB_J;
            level_d  = 1'b0;
            done     = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign tx_out = tx_out_q;
  assign tx_oe  = tx_oe_q;
  assign busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_nrzi_up.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nrzi_up
//  Brief    : Bench for nrzi_up. Two instances (default EOP lengths and a
//             3/2 EOP) share one input stream; each is compared every cycle
//             against a packet-level model, plus directed literal sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nrzi_up;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, start = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, eop_req = 1'b0;

  logic [1:0] taken_v, oe_v, busy_v, done_v, under_v;
  logic [1:0] out_v [2];

  nrzi_up #(.EOP_SE0_BITS(2), .EOP_J_BITS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .eop_req(eop_req), .bit_taken(taken_v[0]),
    .tx_out(out_v[0]), .tx_oe(oe_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .underrun(under_v[0])
  );

  nrzi_up #(.EOP_SE0_BITS(3), .EOP_J_BITS(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .eop_req(eop_req), .bit_taken(taken_v[1]),
    .tx_out(out_v[1]), .tx_oe(oe_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .underrun(under_v[1])
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Packet-level model: a packet is either idle, streaming bits, or playing out
  // an EOP of (SE0 count + J count) bit-times, counted down to zero.
  // ---------------------------------------------------------------------------
  int         M_SE0 [2] = '{2, 3};
  int         M_JB  [2] = '{1, 2};
  logic       m_busy  [2] = '{1'b0, 1'b0};
  logic       m_eop   [2] = '{1'b0, 1'b0};
  logic       m_level [2] = '{1'b0, 1'b0};   // 1 = K
  logic       m_oe    [2] = '{1'b0, 1'b0};
  logic [1:0] m_out   [2] = '{J, J};
  int         m_left  [2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i]  <= 1'b0;
        m_eop[i]   <= 1'b0;
        m_level[i] <= 1'b0;
        m_oe[i]    <= 1'b0;
        m_out[i]   <= J;
        m_left[i]  <= 0;
      end else if (en) begin
        if (!m_busy[i]) begin
          if (start) begin
            m_busy[i]  <= 1'b1;
            m_oe[i]    <= 1'b1;
            m_out[i]   <= J;
            m_level[i] <= 1'b0;
          end
        end else if (m_eop[i]) begin
          if (m_left[i] == 1) begin
            m_busy[i]  <= 1'b0;
            m_eop[i]   <= 1'b0;
            m_oe[i]    <= 1'b0;
            m_out[i]   <= J;
            m_level[i] <= 1'b0;
            m_left[i]  <= 0;
          end else begin
            m_left[i] <= m_left[i] - 1;
            m_out[i]  <= ((m_left[i] - 1) > M_JB[i]) ? SE0 : J;
          end
        end else if (eop_req) begin
          m_eop[i]  <= 1'b1;
          m_left[i] <= M_SE0[i] + M_JB[i];
          m_out[i]  <= SE0;
        end else if (bit_valid) begin
          m_level[i] <= bit_in ? m_level[i] : ~m_level[i];
          m_out[i]   <= (bit_in ? m_level[i] : ~m_level[i]) ? K : J;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mon%0d_out", i),   out_v[i],   m_out[i]);
      chk($sformatf("mon%0d_oe", i),    oe_v[i],    m_oe[i]);
      chk($sformatf("mon%0d_busy", i),  busy_v[i],  m_busy[i]);
      chk($sformatf("mon%0d_taken", i), taken_v[i],
          en && rst_n && m_busy[i] && !m_eop[i] && !eop_req && bit_valid);
      chk($sformatf("mon%0d_under", i), under_v[i],
          en && rst_n && m_busy[i] && !m_eop[i] && !eop_req && !bit_valid);
      chk($sformatf("mon%0d_done", i),  done_v[i],
          en && rst_n && m_eop[i] && (m_left[i] == 1));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus helpers
  // ---------------------------------------------------------------------------
  logic [1:0] l_taken, l_under, l_done;

  // Apply inputs for one clock, capture the combinational pulses mid-cycle,
  // return just after the next rising edge.
  task automatic cyc(input logic e, input logic s, input logic bv, input logic bi,
                     input logic er);
    en = e; start = s; bit_valid = bv; bit_in = bi; eop_req = er;
    @(negedge clk);
    l_taken = taken_v;
    l_under = under_v;
    l_done  = done_v;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_sync [8] = '{K, J, K, J, K, J, K, K};
  logic [1:0] exp_a_out [7] = '{SE0, SE0, J, J, J, J, J};
  logic       exp_a_oe  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       exp_a_dn  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [1:0] exp_b_out [7] = '{SE0, SE0, SE0, J, J, J, J};
  logic       exp_b_oe  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       exp_b_dn  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int   n_taken;
    int   n_done_a, n_done_b;
    logic frz_pulse;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_a", out_v[0], J);
    chk("rst_oe_a", oe_v[0], 1'b0);
    chk("rst_busy_a", busy_v[0], 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // SYNC pattern followed by EOP; start stays high through done to re-arm
    cyc(1, 1, 0, 0, 0);
    chk("lead_out", out_v[0], J);
    chk("lead_oe", oe_v[0], 1'b1);
    n_taken = 0;
    for (int b = 0; b < 8; b++) begin
      cyc(1, 0, 1, (b == 7), 0);
      chk($sformatf("sync_bit%0d", b), out_v[0], exp_sync[b]);
      n_taken += int'(l_taken[0]);
    end
    chk("sync_taken_cnt", 8'(n_taken), 8'd8);

    n_done_a = 0;
    n_done_b = 0;
    for (int k = 0; k < 7; k++) begin
      cyc(1, 1, 0, 0, (k == 0));
      chk($sformatf("eopA_out%0d", k), out_v[0], exp_a_out[k]);
      chk($sformatf("eopA_oe%0d", k),  oe_v[0],  exp_a_oe[k]);
      chk($sformatf("eopA_done%0d", k), l_done[0], exp_a_dn[k]);
      chk($sformatf("eopB_out%0d", k), out_v[1], exp_b_out[k]);
      chk($sformatf("eopB_oe%0d", k),  oe_v[1],  exp_b_oe[k]);
      chk($sformatf("eopB_done%0d", k), l_done[1], exp_b_dn[k]);
      n_done_a += int'(l_done[0]);
      n_done_b += int'(l_done[1]);
    end
    chk("done_once_a", 8'(n_done_a), 8'd1);
    chk("done_once_b", 8'(n_done_b), 8'd1);

    // Close the re-armed packets and drain both instances to idle
    cyc(1, 0, 0, 0, 1);
    repeat (6) cyc(1, 0, 0, 0, 0);
    chk("drain_busy_a", busy_v[0], 1'b0);
    chk("drain_busy_b", busy_v[1], 1'b0);

    // Ones hold the line at K
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    chk("to_k", out_v[0], K);
    for (int b = 0; b < 3; b++) begin
      cyc(1, 0, 1, 1, 0);
      chk($sformatf("hold_k%0d", b), out_v[0], K);
      chk($sformatf("hold_taken%0d", b), l_taken[0], 1'b1);
    end

    // Underrun, then a frozen stretch with en low
    cyc(1, 0, 0, 0, 0);
    chk("underrun_pulse", l_under[0], 1'b1);
    chk("underrun_out", out_v[0], K);
    frz_pulse = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc(0, 1, 1, 0, 1);
      chk($sformatf("frz_out%0d", c), out_v[0], K);
      chk($sformatf("frz_oe%0d", c), oe_v[0], 1'b1);
      frz_pulse = frz_pulse | (|l_taken) | (|l_under) | (|l_done);
    end
    chk("frz_pulses", frz_pulse, 1'b0);

    // eop_req wins over a simultaneous valid bit
    cyc(1, 0, 1, 0, 1);
    chk("eop_wins_taken", l_taken[0], 1'b0);
    chk("eop_wins_out", out_v[0], SE0);

    // Asynchronous reset in the middle of the SE0 run
    cyc(1, 0, 0, 0, 0);
    chk("mid_se0_out", out_v[0], SE0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_oe_a", oe_v[0], 1'b0);
    chk("arst_out_a", out_v[0], J);
    chk("arst_busy_a", busy_v[0], 1'b0);
    chk("arst_done_a", done_v[0], 1'b0);
    chk("arst_oe_b", oe_v[1], 1'b0);
    chk("arst_busy_b", busy_v[1], 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomised traffic with rare asynchronous resets
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 999) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
